// File: rtl/regfile_pkg.sv
// Shared constants, types and FSM encoding for the register-file responder.
// Optional same-edge write forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;
    localparam int BUS_WIDTH  = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [BUS_WIDTH-1:0]  data_t;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } regfile_state_e;
endpackage

// File: rtl/regfile_init_ctrl.sv
// Post-reset clear sequencer: walks every register address once, then parks in READY.
module regfile_init_ctrl
    import regfile_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    output logic           init_busy,
    output logic           clr_en,
    output addr_t          clr_addr,
    output regfile_state_e state
);

    regfile_state_e state_next;
    addr_t          cnt;
    addr_t          cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        init_busy  = 1'b0;
        clr_en     = 1'b0;
        clr_addr   = cnt;
        case (state)
            INIT: begin
                init_busy = 1'b1;
                clr_en    = 1'b1;
                cnt_next  = cnt + 1'b1;
                // The last address is cleared on this edge, so READY follows directly.
                if (cnt == addr_t'(NUM_REGS - 1)) begin
                    state_next = READY;
                end
            end
            READY: begin
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

endmodule

// File: rtl/regfile_responder.sv
// 32-entry register file with x0 tied to zero and two 1-cycle registered read ports.
// Define REGFILE_BYPASS_EN to forward a same-edge write to a matching read.
module regfile_responder
    import regfile_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  addr_t rs1_addr,
    input  logic  rs1_addr_valid,
    input  addr_t rs2_addr,
    input  logic  rs2_addr_valid,
    input  addr_t rd_addr,
    input  logic  rd_wr_en,
    input  data_t rd_data,
    output data_t rs1_data,
    output logic  rs1_data_valid,
    output data_t rs2_data,
    output logic  rs2_data_valid,
    output logic  init_busy
);

    logic           clr_en;
    addr_t          clr_addr;
    regfile_state_e init_state;
    logic           ready;
    logic           wr_fire;
    data_t          regs [NUM_REGS];
    data_t          rs1_next;
    data_t          rs2_next;

    regfile_init_ctrl u_init_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_busy (init_busy),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr),
        .state     (init_state)
    );

    assign ready   = (init_state == READY);
    assign wr_fire = ready && rd_wr_en && (rd_addr != '0);

    // Storage has no reset of its own; the init sweep is what clears it.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            regs[clr_addr] <= '0;
        end else if (wr_fire) begin
            regs[rd_addr] <= rd_data;
        end
    end

    always_comb begin
        rs1_next = regs[rs1_addr];
        rs2_next = regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_fire && (rd_addr == rs1_addr)) begin
            rs1_next = rd_data;
        end
        if (wr_fire && (rd_addr == rs2_addr)) begin
            rs2_next = rd_data;
        end
`endif
        if (rs1_addr == '0) begin
            rs1_next = '0;
        end
        if (rs2_addr == '0) begin
            rs2_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_data       <= '0;
            rs1_data_valid <= 1'b0;
            rs2_data       <= '0;
            rs2_data_valid <= 1'b0;
        end else begin
            rs1_data_valid <= ready && rs1_addr_valid;
            rs2_data_valid <= ready && rs2_addr_valid;
            if (ready && rs1_addr_valid) begin
                rs1_data <= rs1_next;
            end
            if (ready && rs2_addr_valid) begin
                rs2_data <= rs2_next;
            end
        end
    end

endmodule

// File: tb/tb_regfile_responder.sv
// Bench for regfile_responder: vector table plus hand-written reset/init sequences.
module tb_regfile_responder;
    import regfile_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    addr_t rs1_addr, rs2_addr, rd_addr;
    logic  rs1_addr_valid, rs2_addr_valid, rd_wr_en;
    data_t rd_data;
    data_t rs1_data, rs2_data;
    logic  rs1_data_valid, rs2_data_valid, init_busy;

    regfile_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rs1_addr       (rs1_addr),
        .rs1_addr_valid (rs1_addr_valid),
        .rs2_addr       (rs2_addr),
        .rs2_addr_valid (rs2_addr_valid),
        .rd_addr        (rd_addr),
        .rd_wr_en       (rd_wr_en),
        .rd_data        (rd_data),
        .rs1_data       (rs1_data),
        .rs1_data_valid (rs1_data_valid),
        .rs2_data       (rs2_data),
        .rs2_data_valid (rs2_data_valid),
        .init_busy      (init_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model and scoreboard
    data_t mregs [NUM_REGS];
    int    init_left;
    bit    exp_v1, exp_v2;
    data_t last1, last2;
    logic [BUS_WIDTH-1:0] exp1_q[$];
    logic [BUS_WIDTH-1:0] exp2_q[$];

    typedef struct {
        logic  r1v;
        addr_t r1a;
        logic  r2v;
        addr_t r2a;
        logic  we;
        addr_t wa;
        data_t wd;
        logic  v1;
        data_t d1;
        logic  v2;
        data_t d2;
    } vec_t;

    localparam int NVEC = 19;
    vec_t tv [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic data_t model_read(input addr_t a);
        data_t v;
        if (a == '0) return '0;
        v = mregs[a];
`ifdef REGFILE_BYPASS_EN
        if (rd_wr_en && rd_addr == a) v = rd_data;
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) mregs[i] = '0;
        init_left = NUM_REGS;
        last1 = '0;
        last2 = '0;
        exp1_q.delete();
        exp2_q.delete();
    endtask

    task automatic idle_inputs();
        rs1_addr_valid = 1'b0; rs1_addr = '0;
        rs2_addr_valid = 1'b0; rs2_addr = '0;
        rd_wr_en = 1'b0; rd_addr = '0; rd_data = '0;
    endtask

    // One clock: predict from current inputs, advance, then compare.
    task automatic cycle();
        bit busy;
        busy   = (init_left > 0);
        exp_v1 = rs1_addr_valid && !busy;
        exp_v2 = rs2_addr_valid && !busy;
        if (exp_v1) exp1_q.push_back(model_read(rs1_addr));
        if (exp_v2) exp2_q.push_back(model_read(rs2_addr));
        if (busy) init_left--;
        else if (rd_wr_en && rd_addr != '0) mregs[rd_addr] = rd_data;
        @(posedge clk);
        #1;
        chk("init_busy", {31'b0, init_busy}, {31'b0, init_left > 0});
        chk("rs1_valid", {31'b0, rs1_data_valid}, {31'b0, exp_v1});
        chk("rs2_valid", {31'b0, rs2_data_valid}, {31'b0, exp_v2});
        if (exp_v1 && exp1_q.size() > 0) last1 = exp1_q.pop_front();
        if (exp_v2 && exp2_q.size() > 0) last2 = exp2_q.pop_front();
        chk("rs1_data", rs1_data, last1);
        chk("rs2_data", rs2_data, last2);
    endtask

    function automatic vec_t mk(input logic r1v, input int r1a, input logic r2v, input int r2a,
                                input logic we, input int wa, input data_t wd,
                                input logic v1, input data_t d1, input logic v2, input data_t d2);
        vec_t v;
        v.r1v = r1v; v.r1a = addr_t'(r1a);
        v.r2v = r2v; v.r2a = addr_t'(r2a);
        v.we = we; v.wa = addr_t'(wa); v.wd = wd;
        v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tv[0]  = mk(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 32'h0, 0, 32'h0);
        tv[1]  = mk(1, 5, 0, 0, 0, 0, 32'h0, 1, 32'hDEADBEEF, 0, 32'h0);
        tv[2]  = mk(0, 0, 0, 0, 1, 0, 32'h12345678, 0, 32'hDEADBEEF, 0, 32'h0);
        tv[3]  = mk(1, 0, 1, 0, 0, 0, 32'h0, 1, 32'h0, 1, 32'h0);
        tv[4]  = mk(0, 0, 0, 0, 1, 9, 32'h1, 0, 32'h0, 0, 32'h0);
`ifdef REGFILE_BYPASS_EN
        tv[5]  = mk(0, 0, 1, 9, 1, 9, 32'h2, 0, 32'h0, 1, 32'h2);
`else
        tv[5]  = mk(0, 0, 1, 9, 1, 9, 32'h2, 0, 32'h0, 1, 32'h1);
`endif
        tv[6]  = mk(0, 0, 1, 9, 0, 0, 32'h0, 0, 32'h0, 1, 32'h2);
        tv[7]  = mk(0, 0, 0, 0, 1, 1, 32'h11, 0, 32'h0, 0, 32'h2);
        tv[8]  = mk(0, 0, 0, 0, 1, 2, 32'h22, 0, 32'h0, 0, 32'h2);
        tv[9]  = mk(0, 0, 0, 0, 1, 3, 32'h33, 0, 32'h0, 0, 32'h2);
        tv[10] = mk(0, 0, 0, 0, 1, 4, 32'h44, 0, 32'h0, 0, 32'h2);
        tv[11] = mk(1, 1, 0, 0, 0, 0, 32'h0, 1, 32'h11, 0, 32'h2);
        tv[12] = mk(1, 2, 0, 0, 0, 0, 32'h0, 1, 32'h22, 0, 32'h2);
        tv[13] = mk(1, 3, 0, 0, 0, 0, 32'h0, 1, 32'h33, 0, 32'h2);
        tv[14] = mk(1, 4, 0, 0, 0, 0, 32'h0, 1, 32'h44, 0, 32'h2);
        tv[15] = mk(1, 7, 0, 0, 0, 0, 32'h0, 1, 32'h0, 0, 32'h2);
        tv[16] = mk(1, 5, 1, 5, 0, 0, 32'h0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
`ifdef REGFILE_BYPASS_EN
        tv[17] = mk(1, 5, 0, 0, 1, 5, 32'hCAFEF00D, 1, 32'hCAFEF00D, 0, 32'hDEADBEEF);
`else
        tv[17] = mk(1, 5, 0, 0, 1, 5, 32'hCAFEF00D, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF);
`endif
        tv[18] = mk(1, 5, 0, 0, 0, 0, 32'h0, 1, 32'hCAFEF00D, 0, 32'hDEADBEEF);

        // reset state
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        chk("reset_busy", {31'b0, init_busy}, 32'h1);
        chk("reset_v1", {31'b0, rs1_data_valid}, 32'h0);
        chk("reset_v2", {31'b0, rs2_data_valid}, 32'h0);
        chk("reset_d1", rs1_data, 32'h0);
        chk("reset_d2", rs2_data, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // sweep: rs1 asks for x7 and a write to x7 is attempted throughout
        rs1_addr_valid = 1'b1; rs1_addr = 5'd7;
        rd_wr_en = 1'b1; rd_addr = 5'd7; rd_data = 32'hAAAA5555;
        n = 0;
        for (int i = 0; i < 40 && init_busy; i++) begin
            cycle();
            n++;
        end
        chk("init_len", n, 32);
        idle_inputs();

        // vector table
        for (int i = 0; i < NVEC; i++) begin
            rs1_addr_valid = tv[i].r1v; rs1_addr = tv[i].r1a;
            rs2_addr_valid = tv[i].r2v; rs2_addr = tv[i].r2a;
            rd_wr_en = tv[i].we; rd_addr = tv[i].wa; rd_data = tv[i].wd;
            cycle();
            chk("vec_v1", {31'b0, rs1_data_valid}, {31'b0, tv[i].v1});
            chk("vec_d1", rs1_data, tv[i].d1);
            chk("vec_v2", {31'b0, rs2_data_valid}, {31'b0, tv[i].v2});
            chk("vec_d2", rs2_data, tv[i].d2);
        end

        // random traffic against the model
        for (int i = 0; i < 200; i++) begin
            rs1_addr_valid = 1'($urandom_range(0, 1)); rs1_addr = addr_t'($urandom_range(0, 31));
            rs2_addr_valid = 1'($urandom_range(0, 1)); rs2_addr = addr_t'($urandom_range(0, 31));
            rd_wr_en = 1'($urandom_range(0, 1)); rd_addr = addr_t'($urandom_range(0, 31));
            rd_data = data_t'($urandom());
            cycle();
        end
        idle_inputs();

        // set x5, then reset asynchronously while a response is valid
        rd_wr_en = 1'b1; rd_addr = 5'd5; rd_data = 32'h5A5A5A5A;
        cycle();
        idle_inputs();
        rs1_addr_valid = 1'b1; rs1_addr = 5'd5;
        cycle();
        chk("pre_reset_v1", {31'b0, rs1_data_valid}, 32'h1);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("async_v1", {31'b0, rs1_data_valid}, 32'h0);
        chk("async_d1", rs1_data, 32'h0);
        chk("async_busy", {31'b0, init_busy}, 32'h1);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && init_busy; i++) begin
            cycle();
            n++;
        end
        chk("reinit_len", n, 32);
        rs1_addr_valid = 1'b1; rs1_addr = 5'd5;
        cycle();
        chk("x5_cleared_v", {31'b0, rs1_data_valid}, 32'h1);
        chk("x5_cleared_d", rs1_data, 32'h0);
        idle_inputs();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_responder.md
Name: regfile_responder

Overview:
Storage-side responder for the register-file read/write protocol. The testbench driver and monitor act as the initiator: they present source addresses with valid strobes and a destination write.
- Holds 32 general-purpose registers, with x0 hardwired to zero.
- Clears all storage through a sequential init sweep after reset.
- Returns read data with a registered valid strobe one cycle after each request.
- Sits between the decode stage (read requests) and the writeback stage (rd writes).

Parameters:
- BUS_WIDTH, 32, data width of every register and data port
- ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, register count; must equal 2**ADDR_WIDTH

Ports:
- clk  input  1  single clock, all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- rs1_addr  input  ADDR_WIDTH  source 1 address
- rs1_addr_valid  input  1  source 1 read request
- rs2_addr  input  ADDR_WIDTH  source 2 address
- rs2_addr_valid  input  1  source 2 read request
- rd_addr  input  ADDR_WIDTH  destination address
- rd_wr_en  input  1  destination write strobe
- rd_data  input  BUS_WIDTH  destination write data
- rs1_data  output  BUS_WIDTH  source 1 read data
- rs1_data_valid  output  1  source 1 response strobe
- rs2_data  output  BUS_WIDTH  source 2 read data
- rs2_data_valid  output  1  source 2 response strobe
- init_busy  output  1  high while the clear sweep runs

Behaviour:
- Reset (rst_n low, asynchronous): state=INIT, init counter=0. Outputs reset to rs1_data=0, rs2_data=0, rs1_data_valid=0, rs2_data_valid=0, init_busy=1.
- Reset asserted mid-operation: responses in flight are dropped immediately. After deassertion the INIT sweep restarts from counter 0.
- FSM state INIT:
  - Each clk writes 0 to reg[cnt], then cnt+1.
  - When cnt==NUM_REGS-1 is cleared, go to READY on the next edge. Total: 32 cycles after rst_n deasserts.
  - init_busy=1 throughout.
  - Read requests are ignored: no valid pulse is produced.
  - rd writes are dropped.
- FSM state READY:
  - init_busy=0.
  - READY is terminal until reset.
- Reads, per port, independent:
  - If rsN_addr_valid is high at edge T, then rsN_data=reg[rsN_addr] and rsN_data_valid=1 during cycle T+1. Latency is exactly 1 cycle.
  - Back-to-back requests give back-to-back valids. There is no backpressure.
  - With no request, valid=0 the next cycle and rsN_data holds its last value.
  - Address 0 always returns 0.
  - Both ports may read the same address in the same cycle; both return identical data.
- Writes:
  - rd_wr_en high at edge T updates reg[rd_addr]=rd_data, visible to requests sampled at T+1 and later.
  - Writes to rd_addr=0 are discarded.
- Simultaneous write and read to the same nonzero address at the same edge: read-before-write, so the old value is returned (unless the optional feature is enabled).
- Width rules: addresses are unsigned. NUM_REGS is a full power of two, so there is no out-of-range case.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a same-edge write to a nonzero address matching rsN_addr forwards rd_data to rsN_data at T+1.
- Undefined: read-before-write as above.
- Either way, address 0 returns 0.

Decomposition:
- Shared package regfile_pkg:
  - BUS_WIDTH, ADDR_WIDTH, NUM_REGS constants
  - typedef addr_t (logic [ADDR_WIDTH-1:0])
  - typedef data_t (logic [BUS_WIDTH-1:0])
  - enum regfile_state_e {INIT, READY}
- Sub-module regfile_init_ctrl:
  - Owns the FSM and the clear counter.
  - Outputs init_busy, clr_en, clr_addr.
  - The top holds the storage array and the two read pipelines.

Test Plan:
- Reset release, rs1 request to addr 7 during the sweep -> init_busy=1 for exactly 32 cycles, no rs1_data_valid pulse, then init_busy=0.
- After init, write 0xDEADBEEF to x5, then read rs1=5 the next cycle -> rs1_data=0xDEADBEEF with rs1_data_valid=1 exactly 1 cycle after the request.
- Write 0x12345678 to x0, then read rs1=0 and rs2=0 -> both return 0x00000000, both valids high.
- x9=0x1 preloaded, then write 0x2 to x9 and read rs2=9 at the same edge -> 0x1 without REGFILE_BYPASS_EN, 0x2 with it.
- Stream rs1 requests for addrs 1..4 on consecutive cycles with rs2_addr_valid=0 -> rs1 valid held high for 4 cycles with the matching data each cycle; rs2_data_valid stays 0.
- Assert rst_n low while rs1_data_valid=1 -> valid drops to 0 with no clock edge, and x5 reads 0 after the new sweep completes.
